// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port data memory between two requesters
// One transaction in flight: IDLE -> ISSUE -> WAIT -> ACK, every output registered.
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_busy;

    logic              w_any;
    logic              w_winner;
    logic              w_latch;
    logic              w_done;
    logic              w_ack0_nxt;
    logic              w_ack1_nxt;
    logic              w_cap0;
    logic              w_cap1;
    logic              w_busy_nxt;

    // Under contention the port that did not win last time gets the grant.
    always_comb begin
        w_any    = req0 | req1;
        w_winner = 1'b0;
        if (req0 && req1) begin
            w_winner = ~r_last_grant;
        end else if (req1) begin
            w_winner = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, decided one cycle ahead.
    always_comb begin
        w_latch    = (r_state == S_IDLE) && w_any;
        w_done     = (r_state == S_WAIT) && (r_cnt == 4'd1);
        w_ack0_nxt = w_done && !r_grant;
        w_ack1_nxt = w_done && r_grant;
        w_cap0     = w_ack0_nxt && !r_mem_we;
        w_cap1     = w_ack1_nxt && !r_mem_we;
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
            r_mem_en <= w_latch;
            r_busy   <= w_busy_nxt;
            if (w_latch) begin
                r_grant      <= w_winner;
                r_last_grant <= w_winner;
                r_mem_we     <= w_winner ? we1 : we0;
                r_mem_addr   <= w_winner ? addr1 : addr0;
                r_mem_wdata  <= w_winner ? wdata1 : wdata0;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= LAT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_cap0) r_rdata0 <= mem_rdata;
            if (w_cap1) r_rdata1 <= mem_rdata;
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Table-driven single transactions plus hand sequences for contention, reset and long latency.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, mem_en, mem_we, busy;
    logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    logic       t_req0, t_ack0, t_ack1, t_mem_en, t_mem_we, t_busy;
    logic [7:0] t_rdata0, t_rdata1, t_mem_addr, t_mem_wdata, t_mem_rdata;

    logic       mem_load = 1'b1;
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rd [2];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .req0(t_req0), .we0(1'b0), .addr0(8'h44), .wdata0(8'h00), .ack0(t_ack0), .rdata0(t_rdata0),
        .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(8'h00), .ack1(t_ack1), .rdata1(t_rdata1),
        .mem_en(t_mem_en), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
        .mem_rdata(t_mem_rdata), .busy(t_busy)
    );

    // One-cycle-latency memory; read data is only valid in the cycle after mem_en.
    always @(posedge clk) begin
        mem_rdata <= 8'hEE;
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'h5A;
            mem[8'h30] <= 8'h77;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct {
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       port, mwe;
        logic [7:0] maddr, mwdata, rd;
    } vec_t;

    vec_t vt [9];

    function automatic vec_t mk(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                                input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                                input logic port, input logic mwe, input logic [7:0] maddr,
                                input logic [7:0] mwdata, input logic [7:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.port = port; v.mwe = mwe; v.maddr = maddr; v.mwdata = mwdata; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'hFF; wdata0 = 8'hFF;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'hFF; wdata1 = 8'hFF;
    endtask

    // Called at the negedge of an IDLE cycle; requests drop right after being sampled.
    task automatic run_vec(input int idx, input vec_t v);
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
        @(negedge clk);
        idle_inputs();
        chk($sformatf("v%0d mem_en c1", idx), mem_en, 1);
        chk($sformatf("v%0d mem_we", idx), mem_we, v.mwe);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.maddr);
        chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.mwdata);
        chk($sformatf("v%0d busy c1", idx), busy, 1);
        @(negedge clk);
        chk($sformatf("v%0d mem_en c2", idx), mem_en, 0);
        chk($sformatf("v%0d ack c2", idx), {ack1, ack0}, 0);
        @(negedge clk);
        if (!v.mwe) exp_rd[v.port] = v.rd;
        chk($sformatf("v%0d ack0 c3", idx), ack0, (v.port == 1'b0));
        chk($sformatf("v%0d ack1 c3", idx), ack1, (v.port == 1'b1));
        chk($sformatf("v%0d rdata0", idx), rdata0, exp_rd[0]);
        chk($sformatf("v%0d rdata1", idx), rdata1, exp_rd[1]);
        chk($sformatf("v%0d busy c3", idx), busy, 1);
        @(negedge clk);
        chk($sformatf("v%0d ack c4", idx), {ack1, ack0}, 0);
        chk($sformatf("v%0d busy c4", idx), busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
    endtask

    initial begin
        int        n_ack, n_en, prev_ack;
        int        en_cyc [4];
        logic      order [4];
        logic      exp_order [4];
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

        vt[0] = mk(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);
        vt[1] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hC3, 1'b1, 1'b1, 8'h20, 8'hC3, 8'h00);
        vt[2] = mk(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h20, 8'h00, 8'hC3);
        vt[3] = mk(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 8'h5A);
        vt[4] = mk(1'b1, 1'b1, 8'h40, 8'h11, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1, 8'h40, 8'h11, 8'h00);
        vt[5] = mk(1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 8'h50, 8'h22, 1'b1, 1'b1, 8'h50, 8'h22, 8'h00);
        vt[6] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 8'h11);
        vt[7] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00, 8'h22);
        vt[8] = mk(1'b1, 1'b0, 8'h50, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h50, 8'h00, 8'h22);

        idle_inputs();
        t_req0 = 1'b0;
        t_mem_rdata = 8'h99;
        reset = 1'b1;
        @(negedge clk);
        mem_load = 1'b0;
        @(negedge clk);
        chk("rst ack", {ack1, ack0}, 0);
        chk("rst mem_en", mem_en, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst busy", busy, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst rdata", {rdata1, rdata0}, 0);
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;

        for (int i = 0; i < 9; i++) run_vec(i, vt[i]);

        // Both ports held high: strict alternation starting with port 0.
        do_reset();
        n_ack = 0; n_en = 0; prev_ack = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        for (int cyc = 1; cyc <= 24 && n_ack < 4; cyc++) begin
            @(negedge clk);
            if (mem_en && n_en < 4) begin
                en_cyc[n_en] = cyc;
                n_en++;
            end
            if (ack0 || ack1) begin
                chk("rr ack single cycle", prev_ack, 0);
                chk("rr ack one port", {ack1, ack0} == 2'b11, 0);
                order[n_ack] = ack1;
                n_ack++;
                prev_ack = 1;
            end else begin
                prev_ack = 0;
            end
        end
        idle_inputs();
        chk("rr ack count", n_ack, 4);
        chk("rr mem_en count", n_en, 4);
        for (int i = 0; i < 4 && i < n_ack; i++)
            chk($sformatf("rr order %0d", i), order[i], exp_order[i]);
        for (int i = 1; i < 4 && i < n_en; i++)
            chk($sformatf("rr mem_en gap %0d", i), en_cyc[i] - en_cyc[i-1], 4);
        chk("rr rdata0", rdata0, 8'h5A);
        chk("rr rdata1", rdata1, 8'hC3);
        @(negedge clk);
        @(negedge clk);
        chk("rr idle busy", busy, 0);
        chk("rr idle mem_en", mem_en, 0);

        // Reset asserted while waiting for read data aborts without an ack.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        chk("rstw busy before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstw busy", busy, 0);
        chk("rstw mem_en", mem_en, 0);
        chk("rstw ack", {ack1, ack0}, 0);
        chk("rstw rdata0", rdata0, 0);
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        @(negedge clk);
        chk("rstw no late ack", {ack1, ack0}, 0);
        run_vec(100, mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 8'h5A));

        // MEM_LAT=3 instance: only the data driven in cycle 4 may be captured.
        t_req0 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            t_req0 = 1'b0;
            t_mem_rdata = (k == 4) ? 8'hA7 : 8'(8'h30 + k);
            chk($sformatf("lat3 mem_en c%0d", k), t_mem_en, (k == 1));
            chk($sformatf("lat3 ack0 c%0d", k), t_ack0, (k == 5));
            chk($sformatf("lat3 ack1 c%0d", k), t_ack1, 0);
            chk($sformatf("lat3 busy c%0d", k), t_busy, (k <= 5));
            if (k == 1) chk("lat3 mem_addr", t_mem_addr, 8'h44);
            if (k == 5) chk("lat3 rdata0", t_rdata0, 8'hA7);
        end
        chk("lat3 rdata0 hold", t_rdata0, 8'hA7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
